// File: rtl/rf_seq_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the
// register-file execute sequencer.
package rf_seq_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 2;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MOVI = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND with carry (ADD) or
// borrow (SUB) out. MOVI never reaches here and yields zero.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] wide;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_exec_sequencer.sv
// Register-file execute sequencer: accepts one instruction, reads operands,
// executes and issues a single write-back. Optional flags: RF_SEQ_FLAGS_EN.
module rf_exec_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic [DW-1:0] instr_imm,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic          RE,
  output logic [AW-1:0] WR,
  output logic [DW-1:0] WRD,
  output logic          done
`ifdef RF_SEQ_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_c
`endif
);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rs_q, rs_d;
  logic [AW-1:0] rt_q, rt_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] result_q, result_d;

  logic [DW-1:0] alu_result;
  logic          alu_carry;

  rf_seq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

`ifdef RF_SEQ_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
`ifdef RF_SEQ_FLAGS_EN
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d = instr_op;
          rd_d = instr_rd;
          rs_d = instr_rs;
          rt_d = instr_rt;
          // MOVI parks its immediate in the result register and skips the ALU.
          if (instr_op == OP_MOVI) begin
            result_d = instr_imm;
            state_d  = S_WRITE;
          end else begin
            state_d  = S_READ;
          end
        end
      end
      S_READ: begin
        opa_d   = A;
        opb_d   = B;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_result;
`ifdef RF_SEQ_FLAGS_EN
        flag_z_d = (alu_result == '0);
        flag_c_d = alu_carry;
`endif
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
`ifdef RF_SEQ_FLAGS_EN
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
`ifdef RF_SEQ_FLAGS_EN
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
`endif
    end
  end

  // Every RF-side output is a pure decode of registered state.
  assign instr_ready = (state_q == S_IDLE);
  assign RA          = rs_q;
  assign RB          = rt_q;
  assign RE          = (state_q == S_WRITE);
  assign done        = (state_q == S_WRITE);
  assign WR          = rd_q;
  assign WRD         = result_q;
`ifdef RF_SEQ_FLAGS_EN
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
`endif

endmodule

// File: doc/rf_exec_sequencer.md
Name: rf_exec_sequencer

Overview:
- Initiator-side controller for the 4-entry register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives read addresses, captures both operands, computes a result and issues one write-back (write enable, write address, write data).
- Sits between the instruction source (test driver or later the decode stage) and the register file.

Parameters:
- DW, 4, data word width; matches register width.
- AW, 2, register address width; the register file has 2^AW entries.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  an instruction is presented.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_op  input  2  00 ADD, 01 SUB, 10 AND, 11 MOVI.
- instr_rd  input  AW  destination register.
- instr_rs  input  AW  source register driven on RA.
- instr_rt  input  AW  source register driven on RB.
- instr_imm  input  DW  immediate, used only by MOVI.
- RA  output  AW  register file read address A.
- RB  output  AW  register file read address B.
- A  input  DW  register file read data A (combinational from RA).
- B  input  DW  register file read data B (combinational from RB).
- RE  output  1  register file write enable.
- WR  output  AW  register file write address.
- WRD  output  DW  register file write data.
- done  output  1  one-cycle pulse in the cycle the write is issued.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; RA=RB=WR=0; WRD=0; RE=0; done=0; operand and result registers 0. instr_ready=1 because it is decoded from IDLE.
- All RF-side outputs and done are registered or decoded from registered state; no combinational path from instr_* to RE.
- Handshake: transfer occurs when instr_valid and instr_ready are both high at a rising edge. The instruction fields are latched at that edge.
- instr_ready is high only in IDLE. instr_valid arriving while busy is ignored until the sequencer returns to IDLE.
- States:
  - IDLE: waits for a transfer. An ALU op (ADD/SUB/AND) goes to READ; MOVI goes to WRITE.
  - READ: RA=rs, RB=rt; A and B are captured into opa/opb at the end of the cycle; goes to EXEC.
  - EXEC: result = f(opa, opb), truncated modulo 2^DW; goes to WRITE.
  - WRITE: RE=1, WR=rd, WRD=result (or imm for MOVI), done=1; goes to IDLE.
- Latency (edge 0 = accept): ALU op writes in cycle 3 and the register file commits at edge 4. MOVI writes in cycle 1 and commits at edge 2.
- Throughput: at most one ALU op per 4 cycles, one MOVI per 2 cycles.
- Hazards: none. The write commits before the next READ, so back-to-back dependent instructions read the new value.
- rd==rs, rd==rt and rs==rt are all legal and need no special case.
- SUB is opa - opb in two's complement, wrapping.
- RE is high for exactly one cycle per accepted instruction and never otherwise.
- Reset mid-operation aborts the instruction; no write is issued.

Optional Feature:
- Macro RF_SEQ_FLAGS_EN.
- Defined: adds outputs flag_z (1) and flag_c (1), both registered and reset to 0, updated at the end of EXEC.
  - flag_z = (result==0).
  - flag_c: carry-out for ADD, borrow (opa<opb unsigned) for SUB, 0 for AND.
  - MOVI leaves both flags unchanged.
- Undefined: the ports and flag logic do not exist; all other behaviour is identical.

Decomposition:
- Package rf_seq_pkg holds: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_MOVI), state encoding (S_IDLE, S_READ, S_EXEC, S_WRITE), and default DW/AW.
- One combinational sub-module, rf_seq_alu: inputs op, a, b; outputs result, carry. Used in EXEC.

Test Plan:
- With the register file reset to 0: MOVI R1,5; MOVI R2,3; ADD R3,R1,R2 -> RE pulses with WR=3, WRD=8 three cycles after accept; R3=8 afterwards.
- SUB R0,R2,R1 (3-5) -> WRD=4'hE; with RF_SEQ_FLAGS_EN, flag_c=1 and flag_z=0.
- MOVI R1,9; ADD R2,R1,R1 -> WRD=2, flag_c=1. Then MOVI R3,4'hC; MOVI R0,4'hA; AND R1,R3,R0 -> WRD=8.
- instr_valid held high continuously with 3 ALU ops -> instr_ready low for 3 cycles after each accept; accepts 4 cycles apart; exactly 3 RE pulses.
- Reset asserted during EXEC of ADD R3 -> RE stays 0, R3 unchanged, state IDLE, instr_ready=1 immediately.
- ADD R1,R1,R1 with R1=5 -> WRD=10. An immediately following SUB R2,R1,R1 reads 10 -> WRD=0, flag_z=1.
